// File: rtl/hemaia_superbank_arbiter_if.sv
// Bundle of the wide TCDM port, narrow XDMA ports and SRAM bank macro signals of one superbank.
// The slave modport is the arbiter side; the master modport is the requester/memory side.
interface hemaia_superbank_arbiter_if #(
    parameter int unsigned NarrowDataWidth = 64,
    parameter int unsigned WideDataWidth   = 512,
    parameter int unsigned AddrWidth       = 10
);
    localparam int unsigned NumBanks = WideDataWidth / NarrowDataWidth;

    logic                                  wide_q_valid_i;
    logic                                  wide_q_ready_o;
    logic                                  wide_q_write_i;
    logic [AddrWidth-1:0]                  wide_q_addr_i;
    logic [WideDataWidth-1:0]              wide_q_data_i;
    logic [WideDataWidth/8-1:0]            wide_q_strb_i;
    logic                                  wide_p_valid_o;
    logic [WideDataWidth-1:0]              wide_p_data_o;

    logic [NumBanks-1:0]                   narrow_q_valid_i;
    logic [NumBanks-1:0]                   narrow_q_ready_o;
    logic [NumBanks-1:0]                   narrow_q_write_i;
    logic [NumBanks*AddrWidth-1:0]         narrow_q_addr_i;
    logic [NumBanks*NarrowDataWidth-1:0]   narrow_q_data_i;
    logic [NumBanks*NarrowDataWidth/8-1:0] narrow_q_strb_i;
    logic [NumBanks-1:0]                   narrow_p_valid_o;
    logic [NumBanks*NarrowDataWidth-1:0]   narrow_p_data_o;

    logic [NumBanks-1:0]                   mem_cs_o;
    logic [NumBanks-1:0]                   mem_wen_o;
    logic [NumBanks*AddrWidth-1:0]         mem_add_o;
    logic [NumBanks*NarrowDataWidth/8-1:0] mem_be_o;
    logic [NumBanks*NarrowDataWidth-1:0]   mem_wdata_o;
    logic [NumBanks*NarrowDataWidth-1:0]   mem_rdata_i;

    modport slave (
        input  wide_q_valid_i, wide_q_write_i, wide_q_addr_i, wide_q_data_i, wide_q_strb_i,
        output wide_q_ready_o, wide_p_valid_o, wide_p_data_o,
        input  narrow_q_valid_i, narrow_q_write_i, narrow_q_addr_i, narrow_q_data_i, narrow_q_strb_i,
        output narrow_q_ready_o, narrow_p_valid_o, narrow_p_data_o,
        output mem_cs_o, mem_wen_o, mem_add_o, mem_be_o, mem_wdata_o,
        input  mem_rdata_i
    );

    modport master (
        output wide_q_valid_i, wide_q_write_i, wide_q_addr_i, wide_q_data_i, wide_q_strb_i,
        input  wide_q_ready_o, wide_p_valid_o, wide_p_data_o,
        output narrow_q_valid_i, narrow_q_write_i, narrow_q_addr_i, narrow_q_data_i, narrow_q_strb_i,
        input  narrow_q_ready_o, narrow_p_valid_o, narrow_p_data_o,
        input  mem_cs_o, mem_wen_o, mem_add_o, mem_be_o, mem_wdata_o,
        output mem_rdata_i
    );
endinterface

// File: rtl/hemaia_superbank_arbiter.sv
// Per-superbank arbiter between one wide request and per-bank narrow requests, with a
// streak counter that bounds how long pending narrow traffic can be starved by the wide port.
module hemaia_superbank_arbiter #(
    parameter int unsigned NarrowDataWidth = 64,
    parameter int unsigned WideDataWidth   = 512,
    parameter int unsigned AddrWidth       = 10,
    parameter int unsigned MaxWideStreak   = 4
) (
    input logic                      clk_i,
    input logic                      rst_i,
    hemaia_superbank_arbiter_if.slave bus
);
    localparam int unsigned NumBanks   = WideDataWidth / NarrowDataWidth;
    localparam int unsigned StrbWidth  = NarrowDataWidth / 8;
    localparam logic [3:0]  StreakMax  = 4'(MaxWideStreak);

    logic [3:0]                          streak_q, streak_d;
    logic                                wide_rd_q, wide_rd_d;
    logic [NumBanks-1:0]                 narrow_rd_q, narrow_rd_d;

    logic                                narrow_pending;
    logic                                sel_wide;
    logic                                wide_ready;
    logic [NumBanks-1:0]                 narrow_ready;
    logic [NumBanks-1:0]                 cs;
    logic [NumBanks-1:0]                 wen;
    logic [NumBanks*AddrWidth-1:0]       add;
    logic [NumBanks*StrbWidth-1:0]       be;
    logic [NumBanks*NarrowDataWidth-1:0] wdata;

    // Wide wins unless narrow is waiting and the wide streak has hit its limit.
    always_comb begin
        narrow_pending = |bus.narrow_q_valid_i;
        sel_wide       = bus.wide_q_valid_i & ~(narrow_pending & (streak_q == StreakMax));
        wide_ready     = 1'b0;
        narrow_ready   = '0;
        cs             = '0;
        wen            = '0;
        add            = '0;
        be             = '0;
        wdata          = '0;
        if (!rst_i) begin
            if (sel_wide) begin
                wide_ready = 1'b1;
                cs         = '1;
                wen        = {NumBanks{bus.wide_q_write_i}};
                add        = {NumBanks{bus.wide_q_addr_i}};
                be         = bus.wide_q_strb_i;
                wdata      = bus.wide_q_data_i;
            end else begin
                for (int k = 0; k < NumBanks; k++) begin
                    if (bus.narrow_q_valid_i[k]) begin
                        narrow_ready[k]                          = 1'b1;
                        cs[k]                                    = 1'b1;
                        wen[k]                                   = bus.narrow_q_write_i[k];
                        add[k*AddrWidth +: AddrWidth]            = bus.narrow_q_addr_i[k*AddrWidth +: AddrWidth];
                        be[k*StrbWidth +: StrbWidth]             = bus.narrow_q_strb_i[k*StrbWidth +: StrbWidth];
                        wdata[k*NarrowDataWidth +: NarrowDataWidth] =
                            bus.narrow_q_data_i[k*NarrowDataWidth +: NarrowDataWidth];
                    end
                end
            end
        end
        wide_rd_d   = wide_ready & ~bus.wide_q_write_i;
        narrow_rd_d = narrow_ready & ~bus.narrow_q_write_i;
        streak_d    = (sel_wide & narrow_pending) ? streak_q + 4'd1 : 4'd0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            streak_q    <= 4'd0;
            wide_rd_q   <= 1'b0;
            narrow_rd_q <= '0;
        end else begin
            streak_q    <= streak_d;
            wide_rd_q   <= wide_rd_d;
            narrow_rd_q <= narrow_rd_d;
        end
    end

    assign bus.wide_q_ready_o   = wide_ready;
    assign bus.narrow_q_ready_o = narrow_ready;
    assign bus.mem_cs_o         = cs;
    assign bus.mem_wen_o        = wen;
    assign bus.mem_add_o        = add;
    assign bus.mem_be_o         = be;
    assign bus.mem_wdata_o      = wdata;

    // Responses in flight while reset is high are dropped, not delivered late.
    assign bus.wide_p_valid_o   = wide_rd_q & ~rst_i;
    assign bus.narrow_p_valid_o = narrow_rd_q & {NumBanks{~rst_i}};
    assign bus.wide_p_data_o    = bus.mem_rdata_i;
    assign bus.narrow_p_data_o  = bus.mem_rdata_i;
endmodule
